// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: register-file / PHY signal bundle for the reset sequencer.
// slave modport is the sequencer side, master is the register-file/PHY side.
interface reset_sequencer_if #(
  parameter int ALERT_W = 16
);
  logic [7:0]         iTRANSMIT;
  logic               iTRANSMIT_WE;
  logic [ALERT_W-1:0] iAlert;
  logic [ALERT_W-1:0] iAlert_Clr;
  logic [7:0]         iRECEIVE_DETECT;
  logic [7:0]         iRECEIVE_BYTE_COUNT;
  logic               iPHY_Done;
  logic [7:0]         oTRANSMIT;
  logic [ALERT_W-1:0] ALERT;
  logic [7:0]         oRECEIVE_DETECT;
  logic [7:0]         oRECEIVE_BYTE_COUNT;
  logic               oPHY_Tx_Req;
  logic [2:0]         oPHY_Tx_Type;
  logic               PHY_Stop_Attempting_Reset;
  logic               oBusy;
  modport slave (
    input  iTRANSMIT, iTRANSMIT_WE, iAlert, iAlert_Clr, iRECEIVE_DETECT, iRECEIVE_BYTE_COUNT, iPHY_Done,
    output oTRANSMIT, ALERT, oRECEIVE_DETECT, oRECEIVE_BYTE_COUNT, oPHY_Tx_Req, oPHY_Tx_Type,
           PHY_Stop_Attempting_Reset, oBusy
  );
  modport master (
    output iTRANSMIT, iTRANSMIT_WE, iAlert, iAlert_Clr, iRECEIVE_DETECT, iRECEIVE_BYTE_COUNT, iPHY_Done,
    input  oTRANSMIT, ALERT, oRECEIVE_DETECT, oRECEIVE_BYTE_COUNT, oPHY_Tx_Req, oPHY_Tx_Type,
           PHY_Stop_Attempting_Reset, oBusy
  );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: drives Hard/Cable Reset signalling on the PHY with timeout and retries.
// Ports: CLK (rising edge), reset (async, active high), bus (reset_sequencer_if.slave):
//   TRANSMIT write strobe/value in, PHY send request/type out, PHY done in,
//   ALERT = iAlert | sticky status bits, receive registers masked while holding off.
module reset_sequencer #(
  parameter int TIMEOUT_CYC = 32,
  parameter int MAX_RETRIES = 3,
  parameter int RX_HOLD     = 4,
  parameter int ALERT_W     = 16
) (
  input logic CLK,
  input logic reset,
  reset_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, SUCCESS, FAIL, HOLD} state_t;
  localparam int TMAX = TIMEOUT_CYC > RX_HOLD ? TIMEOUT_CYC : RX_HOLD;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(RX_HOLD - 1);
  localparam logic [1:0] MAX_R = 2'(MAX_RETRIES);
  state_t state, nextState;
  logic [TW-1:0] timer, nextTimer;
  logic [1:0] attempt, nextAttempt, limit, nextLimit;
  logic [2:0] txType, nextType;
  logic [ALERT_W-1:0] sticky, nextSticky, setBits;
  logic isResetType, hold;
  assign isResetType = bus.iTRANSMIT[2:0] == 3'b101 || bus.iTRANSMIT[2:0] == 3'b110;
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      attempt <= '0;
      limit   <= '0;
      txType  <= '0;
      sticky  <= '0;
    end else begin
      state   <= nextState;
      timer   <= nextTimer;
      attempt <= nextAttempt;
      limit   <= nextLimit;
      txType  <= nextType;
      sticky  <= nextSticky;
    end
  always_comb begin
    nextState = state;
    nextTimer = timer;
    nextAttempt = attempt;
    nextLimit = limit;
    nextType = txType;
    setBits = '0;
    setBits[5] = bus.iTRANSMIT_WE && state != IDLE;
    case (state)
      IDLE:
        if (bus.iTRANSMIT_WE && isResetType) begin
          nextType = bus.iTRANSMIT[2:0];
          nextLimit = bus.iTRANSMIT[5:4] > MAX_R ? MAX_R : bus.iTRANSMIT[5:4];
          nextAttempt = '0;
          nextState = SEND;
        end
      SEND: begin
        nextTimer = '0;
        nextState = WAIT;
      end
      WAIT:
        if (bus.iPHY_Done) nextState = SUCCESS;
        else if (timer == TIMEOUT_LAST) begin
          nextState = attempt < limit ? SEND : FAIL;
          nextAttempt = attempt < limit ? attempt + 2'd1 : attempt;
        end else nextTimer = timer + 1'b1;
      SUCCESS: begin
        setBits[6] = 1'b1;
        nextTimer = '0;
        nextState = HOLD;
      end
      FAIL: begin
        setBits[4] = 1'b1;
        nextTimer = '0;
        nextState = HOLD;
      end
      HOLD:
        if (timer == HOLD_LAST) nextState = IDLE;
        else nextTimer = timer + 1'b1;
      default: nextState = IDLE;
    endcase
    // set is applied after the clear so a same-cycle set survives
    nextSticky = (sticky & ~bus.iAlert_Clr) | setBits;
  end
  assign hold = state == HOLD;
  assign bus.oBusy = state != IDLE;
  assign bus.oPHY_Tx_Req = state == SEND;
  assign bus.PHY_Stop_Attempting_Reset = state == FAIL;
  assign bus.oPHY_Tx_Type = txType;
  assign bus.ALERT = bus.iAlert | sticky;
  assign bus.oTRANSMIT = hold ? '0 : bus.iTRANSMIT;
  assign bus.oRECEIVE_DETECT = hold ? '0 : bus.iRECEIVE_DETECT;
  assign bus.oRECEIVE_BYTE_COUNT = hold ? '0 : bus.iRECEIVE_BYTE_COUNT;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scoreboard bench for reset_sequencer.
module tb_reset_sequencer;
  typedef struct {int c; logic [2:0] t;} txEv_t;
  logic CLK = 0;
  logic reset = 1;
  int cyc = 0;
  int nAssert = 0;
  int nFail = 0;
  txEv_t txExp[$];
  int stopExp[$];
  reset_sequencer_if #(.ALERT_W(16)) bus ();
  reset_sequencer #(.TIMEOUT_CYC(32), .MAX_RETRIES(3), .RX_HOLD(4), .ALERT_W(16)) dut (
    .CLK(CLK), .reset(reset), .bus(bus)
  );
  initial forever #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic wr(input logic [7:0] v);
    bus.iTRANSMIT = v;
    bus.iTRANSMIT_WE = 1;
    @(negedge CLK);
    bus.iTRANSMIT_WE = 0;
  endtask
  task automatic pulseDone();
    bus.iPHY_Done = 1;
    @(negedge CLK);
    bus.iPHY_Done = 0;
  endtask
  task automatic waitUntil(input string tag, input int sel, input int lim);
    logic hit;
    int n;
    n = 0;
    hit = 0;
    while (!hit && n <= lim) begin
      hit = sel == 0 ? bus.oPHY_Tx_Req : sel == 1 ? bus.PHY_Stop_Attempting_Reset : !bus.oBusy;
      if (!hit) begin
        @(negedge CLK);
        n++;
      end
    end
    chk(tag, 32'(hit), 1);
  endtask
  // scoreboard side: every PHY request / stop pulse must match the next expected event
  always @(negedge CLK) begin
    txEv_t e;
    int s;
    if (!reset) begin
      if (bus.oPHY_Tx_Req) begin
        if (txExp.size() == 0) chk("txUnexpected", 32'(cyc), 32'hffffffff);
        else begin
          e = txExp.pop_front();
          chk("txCycle", 32'(cyc), 32'(e.c));
          chk("txType", 32'(bus.oPHY_Tx_Type), 32'(e.t));
        end
      end
      if (bus.PHY_Stop_Attempting_Reset) begin
        if (stopExp.size() == 0) chk("stopUnexpected", 32'(cyc), 32'hffffffff);
        else begin
          s = stopExp.pop_front();
          chk("stopCycle", 32'(cyc), 32'(s));
        end
      end
    end
  end
  initial begin
    int c;
    bus.iTRANSMIT = 8'h00;
    bus.iTRANSMIT_WE = 0;
    bus.iAlert = 16'h0100;
    bus.iAlert_Clr = 16'h0000;
    bus.iRECEIVE_DETECT = 8'hA5;
    bus.iRECEIVE_BYTE_COUNT = 8'h3C;
    bus.iPHY_Done = 0;
    tick(3);
    chk("rstBusy", 32'(bus.oBusy), 0);
    chk("rstTxReq", 32'(bus.oPHY_Tx_Req), 0);
    chk("rstTxType", 32'(bus.oPHY_Tx_Type), 0);
    chk("rstStop", 32'(bus.PHY_Stop_Attempting_Reset), 0);
    chk("rstAlert", 32'(bus.ALERT), 32'h0100);
    chk("rstRxDet", 32'(bus.oRECEIVE_DETECT), 32'hA5);
    reset = 0;
    bus.iAlert = 16'h0000;
    tick(2);
    // Hard Reset, no retries, Done three cycles after the request
    c = cyc;
    txExp.push_back('{c + 1, 3'b101});
    wr(8'h05);
    waitUntil("hardTx", 0, 5);
    chk("hardTxType", 32'(bus.oPHY_Tx_Type), 32'h5);
    tick(2);
    pulseDone();
    chk("hardSuccessBusy", 32'(bus.oBusy), 1);
    chk("hardAlertLate", 32'(bus.ALERT[6]), 0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("holdRxDet", 32'(bus.oRECEIVE_DETECT), 0);
      chk("holdRxCnt", 32'(bus.oRECEIVE_BYTE_COUNT), 0);
      chk("holdTx", 32'(bus.oTRANSMIT), 0);
      chk("holdAlert6", 32'(bus.ALERT[6]), 1);
    end
    tick(1);
    chk("afterHoldBusy", 32'(bus.oBusy), 0);
    chk("afterHoldRxDet", 32'(bus.oRECEIVE_DETECT), 32'hA5);
    chk("afterHoldTx", 32'(bus.oTRANSMIT), 32'h05);
    chk("typeHeld", 32'(bus.oPHY_Tx_Type), 32'h5);
    bus.iAlert_Clr = 16'h0040;
    tick(1);
    bus.iAlert_Clr = 16'h0000;
    chk("clear6", 32'(bus.ALERT), 0);
    // Cable Reset, three retries, Done never arrives
    c = cyc;
    for (int i = 0; i < 4; i++) txExp.push_back('{c + 1 + 33 * i, 3'b110});
    stopExp.push_back(c + 133);
    wr(8'h36);
    waitUntil("cableStop", 1, 200);
    tick(1);
    chk("cableAlert4", 32'(bus.ALERT[4]), 1);
    chk("cableAlert6", 32'(bus.ALERT[6]), 0);
    waitUntil("cableIdle", 2, 10);
    chk("cableTxLeft", 32'(txExp.size()), 0);
    bus.iAlert_Clr = 16'h0070;
    tick(1);
    bus.iAlert_Clr = 16'h0000;
    chk("clear456", 32'(bus.ALERT), 0);
    // Hard Reset, Done on second attempt, discarded write with same-cycle clear
    c = cyc;
    txExp.push_back('{c + 1, 3'b101});
    txExp.push_back('{c + 34, 3'b101});
    wr(8'h25);
    tick(3);
    bus.iAlert_Clr = 16'h0020;
    wr(8'h06);
    bus.iAlert_Clr = 16'h0000;
    chk("discardSetWins", 32'(bus.ALERT[5]), 1);
    tick(1);
    waitUntil("retryTx", 0, 40);
    tick(1);
    pulseDone();
    waitUntil("retryIdle", 2, 10);
    chk("retryAlert", 32'(bus.ALERT[6:4]), 32'b110);
    chk("retryType", 32'(bus.oPHY_Tx_Type), 32'h5);
    bus.iAlert_Clr = 16'h0070;
    tick(1);
    bus.iAlert_Clr = 16'h0000;
    chk("clearAll", 32'(bus.ALERT), 0);
    // reset in the middle of WAIT, then a non-reset type write
    bus.iAlert = 16'h8001;
    c = cyc;
    txExp.push_back('{c + 1, 3'b101});
    wr(8'h05);
    tick(5);
    reset = 1;
    #1;
    chk("midRstBusy", 32'(bus.oBusy), 0);
    chk("midRstAlert", 32'(bus.ALERT), 32'h8001);
    chk("midRstType", 32'(bus.oPHY_Tx_Type), 0);
    chk("midRstStop", 32'(bus.PHY_Stop_Attempting_Reset), 0);
    chk("midRstRxDet", 32'(bus.oRECEIVE_DETECT), 32'hA5);
    tick(2);
    reset = 0;
    tick(1);
    chk("postRstAlert", 32'(bus.ALERT), 32'h8001);
    bus.iAlert = 16'h0000;
    wr(8'h01);
    chk("otherTypeIdle", 32'(bus.oBusy), 0);
    pulseDone();
    tick(2);
    chk("strayDoneIdle", 32'(bus.oBusy), 0);
    chk("strayDoneAlert", 32'(bus.ALERT), 0);
    // Done coincident with the final timeout: success wins
    c = cyc;
    txExp.push_back('{c + 1, 3'b101});
    wr(8'h05);
    waitUntil("edgeTx", 0, 5);
    tick(32);
    pulseDone();
    chk("edgeSuccessBusy", 32'(bus.oBusy), 1);
    chk("edgeNoStop", 32'(bus.PHY_Stop_Attempting_Reset), 0);
    tick(1);
    chk("edgeAlert6", 32'(bus.ALERT[6]), 1);
    chk("edgeAlert4", 32'(bus.ALERT[4]), 0);
    waitUntil("edgeIdle", 2, 10);
    tick(2);
    chk("txQueueEmpty", 32'(txExp.size()), 0);
    chk("stopQueueEmpty", 32'(stopExp.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
